// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - op codes, FSM state encodings and helpers for the MD sequencer
package md_sequencer_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ITER = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

  localparam logic [4:0] LAST_ITER = 5'd31;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - EX/ID stage request and HI/LO result bundle of the MD sequencer
interface md_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        mf_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, cancel, mf_req,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, cancel, mf_req,
    output busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/md_iter_step.sv
// rtl/md_iter_step.sv - one combinational shift-add (multiply) or restoring shift-subtract (divide) step
module md_iter_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem_shift;
  logic        fits;

  always_comb begin
    sum       = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    // Remainder after the shift can reach 33 bits; the difference always fits in 32.
    rem_shift = acc[63:31];
    fits      = rem_shift >= {1'b0, operand};
    acc_next  = {sum, acc[31:1]};
    if (is_div) begin
      if (fits) begin
        acc_next = {rem_shift[31:0] - operand, acc[30:0], 1'b1};
      end else begin
        acc_next = {acc[62:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - 32-iteration MULT/MULTU/DIV/DIVU sequencer with HI/LO registers
module md_sequencer
  import md_sequencer_pkg::*;
(
  input logic           clock,
  input logic           reset,
  md_sequencer_if.slave md
);

  logic [1:0]  state;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] operand;
  logic        div_op;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic [63:0] acc_next;
  logic [63:0] fix_val;
  logic        start_zero;
  logic        start_sa;
  logic        start_sb;

  md_iter_step u_step (
    .is_div  (div_op),
    .acc     (acc),
    .operand (operand),
    .acc_next(acc_next)
  );

  // A zero divisor keeps the raw dividend so the remainder comes out equal to it.
  always_comb begin
    start_zero = md.op[1] & (md.rt_val == 32'd0);
    start_sa   = md.op[0] & md.rs_val[31] & ~start_zero;
    start_sb   = md.op[0] & md.rt_val[31] & ~start_zero;
  end

  always_comb begin
    fix_val = acc;
    if (div_op) begin
      fix_val[31:0]  = mag32(acc[31:0], sign_a ^ sign_b);
      fix_val[63:32] = mag32(acc[63:32], sign_a);
    end else if (sign_a ^ sign_b) begin
      fix_val = -acc;
    end
  end

  assign md.busy  = (state != ST_IDLE);
  assign md.stall = md.busy & md.mf_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      count          <= 5'd0;
      acc            <= 64'd0;
      operand        <= 32'd0;
      div_op         <= 1'b0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      div_zero       <= 1'b0;
      md.hi          <= 32'd0;
      md.lo          <= 32'd0;
      md.done        <= 1'b0;
      md.div_by_zero <= 1'b0;
    end else begin
      md.done        <= 1'b0;
      md.div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (md.start && !md.cancel) begin
            state    <= ST_ITER;
            count    <= 5'd0;
            div_op   <= md.op[1];
            sign_a   <= start_sa;
            sign_b   <= start_sb;
            div_zero <= start_zero;
            acc      <= {32'd0, mag32(md.rs_val, start_sa)};
            operand  <= mag32(md.rt_val, start_sb);
          end
        end
        ST_ITER: begin
          if (md.cancel) begin
            state <= ST_IDLE;
            count <= 5'd0;
          end else begin
            acc   <= acc_next;
            count <= count + 5'd1;
            if (count == LAST_ITER) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!md.cancel) begin
            {md.hi, md.lo} <= fix_val;
            md.done        <= 1'b1;
            md.div_by_zero <= div_zero;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - randomized self-checking bench for md_sequencer against an arithmetic model
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] cur_hilo;

  md_sequencer_if md ();

  md_sequencer dut (
    .clock(clock),
    .reset(reset),
    .md   (md)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected {hi,lo} straight from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_MULT:  res = 64'(sa * sb);
      MD_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFFFFFF};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mf, input logic extra);
    logic [63:0] exp;
    int k;
    exp       = model(op, a, b);
    md.start  = 1'b1;
    md.op     = op;
    md.rs_val = a;
    md.rt_val = b;
    md.mf_req = mf;
    tick();
    md.start  = 1'b0;
    md.op     = 2'($urandom_range(0, 3));
    md.rs_val = $urandom;
    md.rt_val = $urandom;
    k = 0;
    while (!md.done && k < 40) begin
      if (mf) check("stall_busy", 64'(md.stall), 64'd1);
      check("hilo_hold", {md.hi, md.lo}, cur_hilo);
      if (extra && k == 5) md.start = 1'b1;
      if (extra && k == 6) md.start = 1'b0;
      tick();
      k++;
    end
    check("latency", 64'(k), 64'd33);
    check("result", {md.hi, md.lo}, exp);
    check("dbz", 64'(md.div_by_zero), 64'(op[1] && b == 32'd0));
    check("busy_done", 64'(md.busy), 64'd0);
    check("stall_done", 64'(md.stall), 64'd0);
    cur_hilo  = exp;
    md.mf_req = 1'b0;
    tick();
    check("done_pulse", 64'(md.done), 64'd0);
    check("dbz_pulse", 64'(md.div_by_zero), 64'd0);
    check("idle_after", 64'(md.busy), 64'd0);
  endtask

  initial begin
    logic saw_done;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    md.start  = 1'b0;
    md.op     = 2'b00;
    md.rs_val = 32'd0;
    md.rt_val = 32'd0;
    md.cancel = 1'b0;
    md.mf_req = 1'b1;
    reset     = 1'b1;
    cur_hilo  = 64'd0;
    #2 reset = 1'b0;
    #1;
    check("rst_hilo", {md.hi, md.lo}, 64'd0);
    check("rst_busy", 64'(md.busy), 64'd0);
    check("rst_stall", 64'(md.stall), 64'd0);
    check("rst_done", 64'(md.done), 64'd0);
    check("rst_dbz", 64'(md.div_by_zero), 64'd0);
    md.mf_req = 1'b0;
    #20 reset = 1'b1;
    tick();

    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("multu_max", {md.hi, md.lo}, 64'hFFFFFFFE_00000001);
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    check("mult_neg", {md.hi, md.lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_neg", {md.hi, md.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(MD_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
    check("divu_zero", {md.hi, md.lo}, 64'h00000064_FFFFFFFF);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("div_ovf", {md.hi, md.lo}, 64'h00000000_80000000);
    run_op(MD_DIV, 32'hFFFFFF9C, 32'd0, 1'b1, 1'b0);
    run_op(MD_MULTU, 32'd5, 32'd5, 1'b1, 1'b1);
    check("multu_25", {md.hi, md.lo}, 64'd25);

    // Cancel mid-iteration
    md.start  = 1'b1;
    md.op     = MD_DIV;
    md.rs_val = 32'd9;
    md.rt_val = 32'd3;
    tick();
    md.start = 1'b0;
    repeat (10) tick();
    md.cancel = 1'b1;
    tick();
    md.cancel = 1'b0;
    check("cancel_busy", 64'(md.busy), 64'd0);
    check("cancel_hilo", {md.hi, md.lo}, cur_hilo);
    saw_done = 1'b0;
    repeat (40) begin
      if (md.done) saw_done = 1'b1;
      tick();
    end
    check("cancel_no_done", 64'(saw_done), 64'd0);

    // Cancel in the fix-up cycle
    md.start  = 1'b1;
    md.op     = MD_MULTU;
    md.rs_val = 32'd12345;
    md.rt_val = 32'd678;
    tick();
    md.start = 1'b0;
    repeat (32) tick();
    check("fix_busy", 64'(md.busy), 64'd1);
    md.cancel = 1'b1;
    tick();
    md.cancel = 1'b0;
    check("fix_cancel_done", 64'(md.done), 64'd0);
    check("fix_cancel_busy", 64'(md.busy), 64'd0);
    check("fix_cancel_hilo", {md.hi, md.lo}, cur_hilo);

    // Cancel and start together in IDLE
    md.start  = 1'b1;
    md.cancel = 1'b1;
    tick();
    md.start  = 1'b0;
    md.cancel = 1'b0;
    check("cancel_wins", 64'(md.busy), 64'd0);

    // Reset mid-operation
    md.start  = 1'b1;
    md.op     = MD_MULTU;
    md.rs_val = 32'd1000;
    md.rt_val = 32'd1000;
    tick();
    md.start  = 1'b0;
    repeat (20) tick();
    md.mf_req = 1'b1;
    reset     = 1'b0;
    #1;
    check("midrst_hilo", {md.hi, md.lo}, 64'd0);
    check("midrst_busy", 64'(md.busy), 64'd0);
    check("midrst_stall", 64'(md.stall), 64'd0);
    check("midrst_done", 64'(md.done), 64'd0);
    cur_hilo = 64'd0;
    tick();
    tick();
    reset     = 1'b1;
    md.mf_req = 1'b0;
    saw_done  = 1'b0;
    repeat (15) begin
      if (md.done || md.busy) saw_done = 1'b1;
      tick();
    end
    check("postrst_quiet", 64'(saw_done), 64'd0);
    run_op(MD_MULTU, 32'd2, 32'd3, 1'b0, 1'b0);
    check("postrst_lo", 64'(md.lo), 64'd6);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
